// File: rtl/obi_wb_pkg.sv
// Shared types and constants for the OBI-to-Wishbone bridge.
// State encoding, default parameter values and the outstanding-counter width helper.
package obi_wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_DATA_W          = 32;
    localparam int DEF_MAX_OUTSTANDING = 2;
    localparam int DEF_TIMEOUT_CYCLES  = 1024;

    // Counter must represent 0..max_out inclusive.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/obi_wb_watchdog.sv
// Hung-slave watchdog: counts cycles without a response while transactions are outstanding.
// Used by obi_wb_bridge only when OBI_WB_TIMEOUT_EN is defined.
module obi_wb_watchdog
    import obi_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wd;

    assign expired = count_en & ~clear & (wd == LIMIT);

    // Restart from zero after expiry so a later hang is timed afresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
        end else if (clear || !count_en || expired) begin
            wd <= '0;
        end else begin
            wd <= wd + WW'(1);
        end
    end

endmodule

// File: rtl/obi_wb_bridge.sv
// OBI (req/gnt/rvalid) to pipelined Wishbone master bridge with in-order outstanding tracking.
// Optional hung-slave recovery is compiled in with the OBI_WB_TIMEOUT_EN macro.
module obi_wb_bridge
    import obi_wb_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  obi_req_i,
    output logic                  obi_gnt_o,
    input  logic [ADDR_W-1:0]     obi_addr_i,
    input  logic                  obi_we_i,
    input  logic [DATA_W/8-1:0]   obi_be_i,
    input  logic [DATA_W-1:0]     obi_wdata_i,
    output logic                  obi_rvalid_o,
    output logic [DATA_W-1:0]     obi_rdata_o,
    output logic                  obi_err_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [DATA_W/8-1:0]   wb_sel_o,
    output logic [ADDR_W-1:0]     wb_adr_o,
    output logic [DATA_W-1:0]     wb_dat_o,
    input  logic [DATA_W-1:0]     wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_stall_i,
    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam int CW = cnt_width(MAX_OUTSTANDING);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    state_t              state;
    state_t              state_next;
    logic   [CW-1:0]     cnt;
    logic   [CW-1:0]     cnt_next;
    logic                room;
    logic                accept;
    logic                resp;
    logic                flush;
    logic                flush_emit;
    logic                expire;
    logic                rvalid_q;
    logic                err_q;
    logic   [DATA_W-1:0] rdata_q;

    assign flush      = (state == FLUSH);
    assign room       = (cnt < MAX_CNT);
    assign wb_stb_o   = obi_req_i & room & ~flush;
    assign obi_gnt_o  = wb_stb_o & ~wb_stall_i;
    assign accept     = obi_gnt_o;
    assign wb_cyc_o   = (wb_stb_o | (cnt != '0)) & ~flush;
    assign wb_adr_o   = obi_addr_i;
    assign wb_dat_o   = obi_wdata_i;
    assign wb_sel_o   = obi_be_i;
    assign wb_we_o    = obi_we_i;
    assign busy_o     = (cnt != '0) | flush;

    // A zero-wait slave may ack in the same cycle the request is accepted.
    assign resp       = (wb_ack_i | wb_err_i) & ((cnt != '0) | accept) & ~flush;
    assign flush_emit = flush & (cnt != '0);

`ifdef OBI_WB_TIMEOUT_EN
    obi_wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .clear    ((cnt == '0) | resp),
        .count_en (state == ACTIVE),
        .expired  (expire)
    );
    assign timeout_o = expire;
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        cnt_next = cnt;
        if (flush_emit) begin
            cnt_next = cnt - CW'(1);
        end else if (accept && !resp) begin
            cnt_next = cnt + CW'(1);
        end else if (resp && !accept) begin
            cnt_next = cnt - CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cnt_next != '0) state_next = ACTIVE;
            ACTIVE: begin
                if (cnt_next == '0) begin
                    state_next = IDLE;
                end else if (expire) begin
                    state_next = FLUSH;
                end
            end
            FLUSH:   if (cnt_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Error beats the ack when both arrive; flushed transactions return error with zero data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= resp | flush_emit;
            if (resp) begin
                rdata_q <= wb_dat_i;
                err_q   <= wb_err_i;
            end else if (flush_emit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else begin
                err_q   <= 1'b0;
            end
        end
    end

    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Directed self-checking bench for obi_wb_bridge with a response scoreboard.
// Exercises the watchdog path when OBI_WB_TIMEOUT_EN is defined, otherwise the hang behaviour.
module tb_obi_wb_bridge;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 2;
    localparam int TMO     = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              obi_req_i;
    logic              obi_gnt_o;
    logic [ADDR_W-1:0] obi_addr_i;
    logic              obi_we_i;
    logic [3:0]        obi_be_i;
    logic [DATA_W-1:0] obi_wdata_i;
    logic              obi_rvalid_o;
    logic [DATA_W-1:0] obi_rdata_o;
    logic              obi_err_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [3:0]        wb_sel_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic              wb_stall_i;
    logic              busy_o;
    logic              timeout_o;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    resp_t exp_r;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    obi_wb_bridge #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .MAX_OUTSTANDING (MAX_OUT),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rdata_o  (obi_rdata_o),
        .obi_err_o    (obi_err_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_sel_o     (wb_sel_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .wb_stall_i   (wb_stall_i),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic ack, input logic err,
                                 input logic stall, input logic [31:0] dat);
        obi_req_i   = req;
        obi_we_i    = we;
        obi_addr_i  = addr;
        obi_wdata_i = wdata;
        obi_be_i    = req ? 4'hF : 4'h0;
        wb_ack_i    = ack;
        wb_err_i    = err;
        wb_stall_i  = stall;
        wb_dat_i    = dat;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expectResp(input logic [31:0] d, input logic e);
        resp_t r;
        r.rdata = d;
        r.err   = e;
        exp_q.push_back(r);
    endtask

    task automatic endCycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rvalid must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && obi_rvalid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_rvalid actual rdata=%h err=%b expected no response",
                         obi_rdata_o, obi_err_o);
            end else begin
                exp_r = exp_q.pop_front();
                if (obi_rdata_o !== exp_r.rdata || obi_err_o !== exp_r.err) begin
                    errors++;
                    $display("[TB] FAIL resp_data actual rdata=%h err=%b expected rdata=%h err=%b",
                             obi_rdata_o, obi_err_o, exp_r.rdata, exp_r.err);
                end
            end
        end
    end

    initial begin
        idleInputs();
        @(negedge clk);
        checkOutput("rst_gnt", obi_gnt_o, 1'b0);
        checkOutput("rst_cyc", wb_cyc_o, 1'b0);
        checkOutput("rst_rvalid", obi_rvalid_o, 1'b0);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_timeout", timeout_o, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] single read");
        expectResp(32'hDEADBEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("sr_gnt", obi_gnt_o, 1'b1);
        checkWord("sr_adr", wb_adr_o, 32'h100);
        checkOutput("sr_rvalid_c0", obi_rvalid_o, 1'b0);
        endCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("sr_rvalid_c1", obi_rvalid_o, 1'b1);
        checkOutput("sr_busy_c1", busy_o, 1'b0);
        endCycle();

        $display("[TB] pipelined writes");
        expectResp(32'h11, 1'b0);
        expectResp(32'h22, 1'b0);
        expectResp(32'h33, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h200, 32'hA0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("pw_gnt_p0", obi_gnt_o, 1'b1);
        checkOutput("pw_we_p0", wb_we_o, 1'b1);
        checkWord("pw_dat_p0", wb_dat_o, 32'hA0);
        endCycle();
        applyStimulus(1'b1, 1'b1, 32'h204, 32'hB0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("pw_gnt_p1", obi_gnt_o, 1'b1);
        endCycle();
        applyStimulus(1'b1, 1'b1, 32'h208, 32'hC0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("pw_gnt_p2_full", obi_gnt_o, 1'b0);
        checkOutput("pw_stb_p2_full", wb_stb_o, 1'b0);
        checkOutput("pw_cyc_p2", wb_cyc_o, 1'b1);
        endCycle();
        applyStimulus(1'b1, 1'b1, 32'h208, 32'hC0, 1'b1, 1'b0, 1'b0, 32'h11);
        @(negedge clk);
        checkOutput("pw_gnt_p3_no_bypass", obi_gnt_o, 1'b0);
        endCycle();
        applyStimulus(1'b1, 1'b1, 32'h208, 32'hC0, 1'b1, 1'b0, 1'b0, 32'h22);
        @(negedge clk);
        checkOutput("pw_gnt_p4", obi_gnt_o, 1'b1);
        checkOutput("pw_rvalid_p4", obi_rvalid_o, 1'b1);
        endCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("pw_rvalid_p5", obi_rvalid_o, 1'b1);
        endCycle();
        @(negedge clk);
        checkOutput("pw_rvalid_p6", obi_rvalid_o, 1'b0);
        checkOutput("pw_busy_p6", busy_o, 1'b1);
        endCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h33);
        endCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("pw_rvalid_p8", obi_rvalid_o, 1'b1);
        checkOutput("pw_busy_p8", busy_o, 1'b0);
        endCycle();

        $display("[TB] stall");
        expectResp(32'h44, 1'b0);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("st_gnt_s%0d", s), obi_gnt_o, 1'b0);
            checkWord($sformatf("st_adr_s%0d", s), wb_adr_o, 32'h300);
            endCycle();
        end
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("st_gnt_release", obi_gnt_o, 1'b1);
        checkWord("st_adr_release", wb_adr_o, 32'h300);
        endCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h44);
        endCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("st_rvalid", obi_rvalid_o, 1'b1);
        endCycle();

        $display("[TB] error response");
        expectResp(32'h55, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        endCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h55);
        endCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("er_rvalid", obi_rvalid_o, 1'b1);
        checkOutput("er_err", obi_err_o, 1'b1);
        endCycle();

        $display("[TB] spurious ack");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h66);
        endCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("sp_rvalid", obi_rvalid_o, 1'b0);
        checkOutput("sp_busy", busy_o, 1'b0);
        endCycle();

        $display("[TB] hung slave");
`ifdef OBI_WB_TIMEOUT_EN
        expectResp(32'h0, 1'b1);
        expectResp(32'h0, 1'b1);
`else
        expectResp(32'h81, 1'b0);
        expectResp(32'h82, 1'b0);
`endif
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("hs_gnt_w0", obi_gnt_o, 1'b1);
        endCycle();
        applyStimulus(1'b1, 1'b0, 32'h504, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("hs_gnt_w1", obi_gnt_o, 1'b1);
        endCycle();
        for (int k = 2; k <= 21; k++) begin
`ifdef OBI_WB_TIMEOUT_EN
            if (k == 20) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h77);
            else idleInputs();
            @(negedge clk);
            checkOutput($sformatf("wd_timeout_w%0d", k), timeout_o, k == 16);
            checkOutput($sformatf("wd_cyc_w%0d", k), wb_cyc_o, k <= 16);
            checkOutput($sformatf("wd_rvalid_w%0d", k), obi_rvalid_o, k == 18 || k == 19);
            checkOutput($sformatf("wd_busy_w%0d", k), busy_o, k <= 18);
`else
            idleInputs();
            @(negedge clk);
            checkOutput($sformatf("hang_timeout_w%0d", k), timeout_o, 1'b0);
            checkOutput($sformatf("hang_cyc_w%0d", k), wb_cyc_o, 1'b1);
            checkOutput($sformatf("hang_busy_w%0d", k), busy_o, 1'b1);
`endif
            endCycle();
        end
`ifndef OBI_WB_TIMEOUT_EN
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h81);
        endCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h82);
        endCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("hang_drain_rvalid", obi_rvalid_o, 1'b1);
        checkOutput("hang_drain_busy", busy_o, 1'b0);
        endCycle();
`endif

        $display("[TB] async reset mid-transaction");
        applyStimulus(1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        endCycle();
        applyStimulus(1'b1, 1'b0, 32'h604, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        endCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("ar_busy_before", busy_o, 1'b1);
        checkOutput("ar_cyc_before", wb_cyc_o, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_cyc", wb_cyc_o, 1'b0);
        checkOutput("ar_stb", wb_stb_o, 1'b0);
        checkOutput("ar_gnt", obi_gnt_o, 1'b0);
        checkOutput("ar_rvalid", obi_rvalid_o, 1'b0);
        checkOutput("ar_err", obi_err_o, 1'b0);
        checkOutput("ar_busy", busy_o, 1'b0);
        checkWord("ar_rdata", obi_rdata_o, 32'h0);
        endCycle();
        rst_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            if (r == 0) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h99);
            else idleInputs();
            @(negedge clk);
            checkOutput($sformatf("ar_post_rvalid_%0d", r), obi_rvalid_o, 1'b0);
            checkOutput($sformatf("ar_post_busy_%0d", r), busy_o, 1'b0);
            endCycle();
        end

        checkWord("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
